// File: rtl/fetch_flow_controller.sv
// Fetch front-end sequencer: runs the imem request handshake and turns hazards,
// taken branches and MEM stalls into PC / IF-ID / ID-EXE freeze and flush controls.
module fetch_flow_controller #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard,
  input  logic             branch_taken,
  input  logic             mem_stall,
  input  logic             imem_ack,
  output logic             imem_req,
  output logic             pc_freeze,
  output logic             if_freeze,
  output logic             if_flush,
  output logic             id_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             timeout_err
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_DISCARD
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              timeout_err_q, timeout_err_d;

  logic br;
  logic fetch_done;

  // A redirect only counts when the front end is not frozen by MEM.
  assign br         = branch_taken & ~mem_stall;
  assign fetch_done = imem_ack & ((state_q == ST_FETCH) | (state_q == ST_WAIT));

  assign imem_req  = (state_q != ST_IDLE);
  assign pc_freeze = mem_stall | (~branch_taken & (hazard | ~fetch_done));
  assign if_freeze = mem_stall | (hazard & ~branch_taken);
  assign if_flush  = ~if_freeze & (branch_taken | ~fetch_done);
  assign id_flush  = ~mem_stall & (branch_taken | hazard);

  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign timeout_err = timeout_err_q;

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
    unique case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          state_d = ST_FETCH;
        end else begin
          state_d    = br ? ST_DISCARD : ST_WAIT;
          wait_cnt_d = '0;
        end
      end
      // WAIT and DISCARD age the outstanding request identically; a branch
      // restarts the wait for the word that must now be thrown away.
      ST_WAIT, ST_DISCARD: begin
        if (imem_ack) begin
          state_d = ST_FETCH;
        end else if (br) begin
          state_d    = ST_DISCARD;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d       = ST_FETCH;
          timeout_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_freeze && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (br && (flush_cnt_q != CNT_MAX))        flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      wait_cnt_q    <= '0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

endmodule
